// File: rtl/bus_ack_pkg.sv
// Shared definitions for the bus/ack mailbox: FSM state encoding and
// default parameter values used by the mailbox, its RAM and its interface.
package bus_ack_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Occupancy state of the mailbox.
  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    ACTIVE = 2'd1,
    FULL   = 2'd2
  } state_t;

endpackage

// File: rtl/bus_ack_mailbox_if.sv
// Producer/consumer handshake bundle of the mailbox. The master side is the
// environment (producer + consumer); the slave side is the mailbox itself.
interface bus_ack_mailbox_if
  import bus_ack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);

  logic                   FlagIn;
  logic [WIDTH-1:0]       BusIn;
  logic                   Busy;
  logic                   FlagOut;
  logic                   Valid;
  logic [WIDTH-1:0]       BusOut;
  logic                   AckIn;
  logic [$clog2(DEPTH):0] Level;
  logic                   Overflow;
  logic                   Underflow;
  logic                   ClearErr;

  modport master (
    output FlagIn, BusIn, AckIn, ClearErr,
    input  Busy, FlagOut, Valid, BusOut, Level, Overflow, Underflow
  );

  modport slave (
    input  FlagIn, BusIn, AckIn, ClearErr,
    output Busy, FlagOut, Valid, BusOut, Level, Overflow, Underflow
  );

endinterface

// File: rtl/bus_ack_ram.sv
// Mailbox storage: WIDTH x DEPTH array, one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module bus_ack_ram
  import bus_ack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store the producer word at the write address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/bus_ack_mailbox.sv
// Mailbox with flag/ack handshake: pointers, occupancy level, EMPTY/ACTIVE/FULL
// FSM, registered head word with a "new head" pulse, and sticky error flags.
module bus_ack_mailbox
  import bus_ack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input logic              clk,
  input logic              rst,
  bus_ack_mailbox_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] LVL_ZERO = '0;
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_LAST = LW'(DEPTH - 1);

  state_t           state_reg, state_next;
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_inc;
  logic [LW-1:0]    level_reg, level_next;
  logic [WIDTH-1:0] bus_out_reg, bus_out_next, ram_rd_data;
  logic             flag_out_reg, flag_out_next;
  logic             ovf_reg, ovf_next, udf_reg, udf_next;
  logic             busy, valid, wr_acc, pop_acc, head_change;

  // Busy/Valid are pure decodes of the state register, so they are glitch-free
  // registered outputs. A write in FULL is refused even if a pop coincides.
  assign busy       = (state_reg == FULL);
  assign valid      = (state_reg != EMPTY);
  assign wr_acc     = bus.FlagIn & ~busy;
  assign pop_acc    = bus.AckIn & valid;
  assign rd_ptr_inc = rd_ptr_reg + PTR_ONE;

  // The read port looks one entry ahead so the next head can be loaded into
  // the BusOut register on the same edge as the pop.
  bus_ack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we      (wr_acc & ~rst),
    .wr_addr (wr_ptr_reg),
    .wr_data (bus.BusIn),
    .rd_addr (rd_ptr_inc),
    .rd_data (ram_rd_data)
  );

  // Next-state logic of the occupancy FSM.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      EMPTY:  if (wr_acc) state_next = ACTIVE;
      ACTIVE: begin
        if (wr_acc && !pop_acc && level_reg == LVL_LAST) begin
          state_next = FULL;
        end else if (pop_acc && !wr_acc && level_reg == LVL_ONE) begin
          state_next = EMPTY;
        end
      end
      FULL:   if (pop_acc) state_next = ACTIVE;
      default: state_next = EMPTY;
    endcase
  end

  // Level, head word, new-head pulse and sticky error flags.
  always_comb begin
    level_next = level_reg;
    case ({wr_acc, pop_acc})
      2'b10:   level_next = level_reg + LVL_ONE;
      2'b01:   level_next = level_reg - LVL_ONE;
      default: level_next = level_reg;
    endcase

    // A new head appears when writing into an empty mailbox, when popping with
    // a second word behind the head, or when a pop of the last word coincides
    // with a write (the written word then becomes head directly).
    head_change = (wr_acc & (level_reg == LVL_ZERO))
                | (pop_acc & ((level_reg > LVL_ONE) | wr_acc));

    bus_out_next = bus_out_reg;
    if (pop_acc && level_reg > LVL_ONE) begin
      bus_out_next = ram_rd_data;
    end else if (head_change) begin
      bus_out_next = bus.BusIn;
    end
    flag_out_next = head_change;

    // Setting a fault wins over a same-cycle clear.
    ovf_next = ovf_reg;
    if (bus.FlagIn && busy) begin
      ovf_next = 1'b1;
    end else if (bus.ClearErr) begin
      ovf_next = 1'b0;
    end

    udf_next = udf_reg;
    if (bus.AckIn && !valid) begin
      udf_next = 1'b1;
    end else if (bus.ClearErr) begin
      udf_next = 1'b0;
    end
  end

  // Register all control and output state; reset discards stored words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= EMPTY;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      bus_out_reg  <= '0;
      flag_out_reg <= 1'b0;
      ovf_reg      <= 1'b0;
      udf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      if (wr_acc)  wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_acc) rd_ptr_reg <= rd_ptr_inc;
      level_reg    <= level_next;
      bus_out_reg  <= bus_out_next;
      flag_out_reg <= flag_out_next;
      ovf_reg      <= ovf_next;
      udf_reg      <= udf_next;
    end
  end

  assign bus.Busy      = busy;
  assign bus.Valid     = valid;
  assign bus.Level     = level_reg;
  assign bus.BusOut    = bus_out_reg;
  assign bus.FlagOut   = flag_out_reg;
  assign bus.Overflow  = ovf_reg;
  assign bus.Underflow = udf_reg;

endmodule

// File: tb/tb_bus_ack_mailbox.sv
// Self-checking bench for bus_ack_mailbox (WIDTH=8, DEPTH=4): directed
// scenarios followed by random traffic, checked against a reference queue.
module tb_bus_ack_mailbox;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  bus_ack_mailbox_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus_if ();

  bus_ack_mailbox #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [WIDTH-1:0] sb_q [$];
  logic [WIDTH-1:0] m_bus;
  logic             m_flag, m_ovf, m_udf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".Level"},     64'(bus_if.Level),     64'(sb_q.size()));
    check({tag, ".Valid"},     64'(bus_if.Valid),     64'(sb_q.size() > 0));
    check({tag, ".Busy"},      64'(bus_if.Busy),      64'(sb_q.size() == DEPTH));
    check({tag, ".BusOut"},    64'(bus_if.BusOut),    64'(m_bus));
    check({tag, ".FlagOut"},   64'(bus_if.FlagOut),   64'(m_flag));
    check({tag, ".Overflow"},  64'(bus_if.Overflow),  64'(m_ovf));
    check({tag, ".Underflow"}, 64'(bus_if.Underflow), 64'(m_udf));
  endtask

  // One clock cycle of stimulus; the model predicts the outputs after the edge.
  task automatic step(input string tag, input logic f, input logic [WIDTH-1:0] d,
                      input logic a, input logic c);
    int  size_before;
    logic full_before, empty_before, wr, pop;
    bus_if.FlagIn   = f;
    bus_if.BusIn    = d;
    bus_if.AckIn    = a;
    bus_if.ClearErr = c;
    size_before  = sb_q.size();
    full_before  = (size_before == DEPTH);
    empty_before = (size_before == 0);
    wr  = f && !full_before;
    pop = a && !empty_before;
    if (pop) begin
      check({tag, ".pop_data"}, 64'(bus_if.BusOut), 64'(sb_q[0]));
      void'(sb_q.pop_front());
    end
    if (wr) sb_q.push_back(d);
    if (f && full_before)       m_ovf = 1'b1;
    else if (c)                 m_ovf = 1'b0;
    if (a && empty_before)      m_udf = 1'b1;
    else if (c)                 m_udf = 1'b0;
    m_flag = (sb_q.size() > 0) && (pop || size_before == 0);
    if (sb_q.size() > 0) m_bus = sb_q[0];
    @(posedge clk);
    #1;
    $display("step %-12s f=%0d d=%02h a=%0d c=%0d -> lvl=%0d valid=%0d busy=%0d out=%02h flag=%0d ovf=%0d udf=%0d",
             tag, f, d, a, c, bus_if.Level, bus_if.Valid, bus_if.Busy, bus_if.BusOut,
             bus_if.FlagOut, bus_if.Overflow, bus_if.Underflow);
    check_outputs(tag);
  endtask

  // Reset with FlagIn/AckIn asserted to show they are ignored during reset.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    bus_if.FlagIn   = 1'b1;
    bus_if.BusIn    = 8'hEE;
    bus_if.AckIn    = 1'b1;
    bus_if.ClearErr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
    m_bus  = '0;
    m_flag = 1'b0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    $display("reset %-11s -> lvl=%0d valid=%0d busy=%0d out=%02h", tag,
             bus_if.Level, bus_if.Valid, bus_if.Busy, bus_if.BusOut);
    check_outputs(tag);
  endtask

  initial begin
    bus_if.FlagIn   = 1'b0;
    bus_if.BusIn    = '0;
    bus_if.AckIn    = 1'b0;
    bus_if.ClearErr = 1'b0;
    #2;
    do_reset("reset");

    // Single write into EMPTY, one-cycle FlagOut pulse, then drain.
    step("wr_a5", 1'b1, 8'hA5, 1'b0, 1'b0);
    step("idle", 1'b0, 8'h00, 1'b0, 1'b0);
    step("pop_a5", 1'b0, 8'h00, 1'b1, 1'b0);
    step("empty_hold", 1'b0, 8'h00, 1'b0, 1'b0);

    // Five writes without pops: fifth refused, Overflow set.
    for (int i = 1; i <= 5; i++) begin
      step($sformatf("fill%0d", i), 1'b1, 8'(i), 1'b0, 1'b0);
    end

    // Pop and write together in FULL: write refused, head becomes 0x02.
    step("full_wrpop", 1'b1, 8'h66, 1'b1, 1'b0);
    step("clr_ovf", 1'b0, 8'h00, 1'b0, 1'b1);

    // Drain to Level=1, then simultaneous write/pop keeps Level=1.
    step("pop_02", 1'b0, 8'h00, 1'b1, 1'b0);
    step("pop_03", 1'b0, 8'h00, 1'b1, 1'b0);
    step("wrpop_33", 1'b1, 8'h33, 1'b1, 1'b0);
    step("pop_33", 1'b0, 8'h00, 1'b1, 1'b0);

    // Underflow, set-over-clear priority, then clear.
    step("udf", 1'b0, 8'h00, 1'b1, 1'b0);
    step("udf_set_clr", 1'b0, 8'h00, 1'b1, 1'b1);
    step("udf_clr", 1'b0, 8'h00, 1'b0, 1'b1);

    // Reset mid-operation at Level=3.
    step("pre1", 1'b1, 8'h11, 1'b0, 1'b0);
    step("pre2", 1'b1, 8'h22, 1'b0, 1'b0);
    step("pre3", 1'b1, 8'h44, 1'b0, 1'b0);
    do_reset("reset_mid");
    step("post_rst", 1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic against the reference queue.
    for (int i = 0; i < 200; i++) begin
      step($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_ack_mailbox.md
BUS_ACK_MAILBOX -- requirements
Module: bus_ack_mailbox

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data bus width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 4, number of entries; a power of two, 2..256.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port FlagIn  input  1  producer write request.
REQ-006 SHALL have port BusIn  input  WIDTH  producer data, sampled when a write is accepted.
REQ-007 SHALL have port Busy  output  1  mailbox full; writes are refused.
REQ-008 SHALL have port FlagOut  output  1  one-cycle pulse when a new word becomes head.
REQ-009 SHALL have port Valid  output  1  head word present.
REQ-010 SHALL have port BusOut  output  WIDTH  head word.
REQ-011 SHALL have port AckIn  input  1  consumer pop of the head word.
REQ-012 SHALL have port Level  output  $clog2(DEPTH)+1  number of stored words.
REQ-013 SHALL have port Overflow  output  1  sticky: write attempted while Busy.
REQ-014 SHALL have port Underflow  output  1  sticky: AckIn while not Valid.
REQ-015 SHALL have port ClearErr  input  1  clears Overflow and Underflow.

Function
REQ-016 SHALL accept a write when FlagIn & ~Busy; BusIn is stored at the write pointer.
REQ-017 SHALL accept a pop when AckIn & Valid; the read pointer advances.
REQ-018 SHALL wrap both pointers modulo DEPTH; Level = accepted writes minus accepted pops.
REQ-019 SHALL run FSM EMPTY/ACTIVE/FULL: EMPTY->ACTIVE on a write; ACTIVE->FULL when a write without a pop makes Level=DEPTH; ACTIVE->EMPTY when a pop without a write makes Level=0; FULL->ACTIVE on a pop.
REQ-020 SHALL drive Busy=1 exactly in FULL, and Valid=1 exactly in ACTIVE or FULL; both are registered.
REQ-021 SHALL refuse a write in FULL even when a pop occurs in the same cycle; Busy falls the cycle after the pop.
REQ-022 SHALL perform a simultaneous write and pop in ACTIVE with Level unchanged.
REQ-023 SHALL present a word written in EMPTY on BusOut with Valid=1 one cycle after acceptance (latency 1).
REQ-024 SHALL pulse FlagOut for one cycle in the cycle a new word first appears as head: after a write into EMPTY, or after a pop with Level>=2 before the pop.
REQ-025 SHALL hold the last popped value on BusOut while EMPTY.
REQ-026 SHALL set Overflow on FlagIn & Busy and Underflow on AckIn & ~Valid; both hold until ClearErr or rst.
REQ-027 SHALL give a same-cycle set of Overflow or Underflow priority over ClearErr.
REQ-028 SHALL leave stored data and pointers unchanged by refused writes and pops.

Reset
REQ-029 SHALL, when rst=1 at a clock edge, force state EMPTY, both pointers 0, Level=0, Busy=0, Valid=0, FlagOut=0, BusOut=0, Overflow=0 and Underflow=0.
REQ-030 SHALL discard all stored words on reset mid-operation; FlagIn and AckIn are ignored while rst=1.
REQ-031 SHALL NOT reset the storage array contents.

Structure
REQ-032 SHALL place the FSM state typedef (EMPTY, ACTIVE, FULL) and the parameter default constants in shared package bus_ack_pkg.
REQ-033 SHALL implement storage as sub-module bus_ack_ram: WIDTH x DEPTH, one write port, asynchronous read port.
REQ-034 SHALL keep pointers, Level, FSM and flags in bus_ack_mailbox.

Verification
REQ-035 SHALL cover: WIDTH=8, DEPTH=4; write 0xA5 into EMPTY -> next cycle Valid=1, BusOut=0xA5, FlagOut pulses once, Level=1.
REQ-036 SHALL cover: five consecutive writes 0x01..0x05, no pops -> Busy=1 after the fourth, 0x05 dropped, Overflow=1, Level=4.
REQ-037 SHALL cover: FULL state, then AckIn and FlagIn in the same cycle -> write refused, Level=3, Busy=0 next cycle, BusOut=0x02, FlagOut pulses.
REQ-038 SHALL cover: Level=1, simultaneous write 0x33 and pop -> Level stays 1, BusOut=0x33, FlagOut pulses.
REQ-039 SHALL cover: AckIn while EMPTY -> Underflow=1; ClearErr with no new fault -> Underflow=0 next cycle.
REQ-040 SHALL cover: rst asserted at Level=3 -> next cycle Level=0, Valid=0, BusOut=0, then 200 random write/pop cycles checked against a reference queue.
